// File: rtl/starforc_spr_dma.sv
// rtl/starforc_spr_dma.sv - vblank copier of the sprite attribute table into board2 sprite RAM
// Purpose: takes the CPU bus via bus_req/bus_gnt and copies NBYTES bytes from work RAM
//          (SRC_BASE+i) to sprite RAM (CPU_A=i), one SETUP/STROBE/HOLD sequence per byte.
// Ports:   clk48m_i, reset_i (sync, active high); start_i, auto_vbl_i, nVBLANK_i arm/gate a copy;
//          bus_req_o/bus_gnt_i CPU bus handshake; src_addr_o/src_data_i work-RAM read port;
//          CPU_A_o, DCON_out_o, DCON_in_i, nCS_SPR_o, nMEWR_o, nMERD_o connector-2 bus;
//          busy_o, done_o, overrun_o, mismatch_cnt_o status.
// Option:  SPR_DMA_READBACK_EN adds a per-byte READ phase that compares DCON_in against DCON_out.
module starforc_spr_dma #(
  parameter int          NBYTES     = 128,
  parameter logic [10:0] SRC_BASE   = 11'h000,
  parameter int          SETUP_CYC  = 2,
  parameter int          STROBE_CYC = 4
) (
  input  logic        clk48m_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        auto_vbl_i,
  input  logic        nVBLANK_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [10:0] src_addr_o,
  input  logic [7:0]  src_data_i,
  output logic [10:0] CPU_A_o,
  output logic [7:0]  DCON_out_o,
  input  logic [7:0]  DCON_in_i,
  output logic        nCS_SPR_o,
  output logic        nMEWR_o,
  output logic        nMERD_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o,
  output logic [7:0]  mismatch_cnt_o
);

  localparam int            IW          = $clog2(NBYTES);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NBYTES - 1);
  localparam logic [3:0]    SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0]    STROBE_LAST = 4'(STROBE_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETUP, S_STROBE, S_HOLD, S_READ, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [10:0]   src_addr_q, src_addr_d;
  logic [7:0]    dcon_q, dcon_d;
  logic [7:0]    mis_q, mis_d;
  logic          armed_q, armed_d;
  logic          stop_q, stop_d;
  logic          overrun_q, overrun_d;
  logic          nvbl_q;
  logic          arm, in_byte, byte_end, overrun_set;
  logic [IW-1:0] idx_inc;

  assign idx_inc = idx_q + 1'b1;
  assign arm     = start_i | (auto_vbl_i & nvbl_q & ~nVBLANK_i);
  assign in_byte = state_q inside {S_SETUP, S_STROBE, S_HOLD, S_READ};

`ifdef SPR_DMA_READBACK_EN
`else
  logic unused_dcon_in;
  assign unused_dcon_in = ^DCON_in_i;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    src_addr_d  = src_addr_q;
    dcon_d      = dcon_q;
    mis_d       = mis_q;
    armed_d     = armed_q | arm;
    stop_d      = stop_q;
    byte_end    = 1'b0;
    overrun_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d      = '0;
        src_addr_d = SRC_BASE;
        stop_d     = 1'b0;
        if (armed_q && !nVBLANK_i) begin
          state_d = S_REQ;
          armed_d = 1'b0;
        end
      end
      S_REQ: begin
        if (bus_gnt_i) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        // work RAM is one cycle late; src_addr was already stable in the previous cycle
        if (cnt_q == '0) dcon_d = src_data_i;
        if (cnt_q == SETUP_LAST) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
`ifdef SPR_DMA_READBACK_EN
`else
          // present the next source address during the last cycle of this byte
          src_addr_d = SRC_BASE + 11'(idx_inc);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
`ifdef SPR_DMA_READBACK_EN
        state_d    = S_READ;
        cnt_d      = '0;
        src_addr_d = SRC_BASE + 11'(idx_inc);
`else
        byte_end = 1'b1;
`endif
      end
      S_READ: begin
`ifdef SPR_DMA_READBACK_EN
        if (cnt_q == STROBE_LAST) begin
          if (DCON_in_i != dcon_q && mis_q != 8'hFF) mis_d = mis_q + 8'd1;
          byte_end = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (in_byte && nVBLANK_i) stop_d = 1'b1;

    // end of a byte: finishing the table takes precedence over a vblank that ended on the last byte
    if (byte_end) begin
      idx_d = idx_inc;
      if (idx_q == IDX_LAST) begin
        state_d = S_DONE;
      end else if (stop_q || nVBLANK_i) begin
        state_d     = S_IDLE;
        overrun_set = 1'b1;
      end else begin
        state_d = S_SETUP;
        cnt_d   = '0;
      end
    end

    // grant loss aborts the byte outright; it is redone from SETUP after re-grant
    if (in_byte && !bus_gnt_i) begin
      state_d     = S_REQ;
      cnt_d       = '0;
      idx_d       = idx_q;
      src_addr_d  = SRC_BASE + 11'(idx_q);
      mis_d       = mis_q;
      overrun_set = 1'b0;
    end

    overrun_d = overrun_set ? 1'b1 : (start_i ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk48m_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      src_addr_q <= SRC_BASE;
      dcon_q     <= '0;
      mis_q      <= '0;
      armed_q    <= 1'b0;
      stop_q     <= 1'b0;
      overrun_q  <= 1'b0;
      nvbl_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      src_addr_q <= src_addr_d;
      dcon_q     <= dcon_d;
      mis_q      <= mis_d;
      armed_q    <= armed_d;
      stop_q     <= stop_d;
      overrun_q  <= overrun_d;
      nvbl_q     <= nVBLANK_i;
    end
  end

  assign bus_req_o      = (state_q == S_REQ) | in_byte;
  assign busy_o         = bus_req_o;
  assign nCS_SPR_o      = ~in_byte;
  assign nMEWR_o        = ~(state_q == S_STROBE);
  assign nMERD_o        = ~(state_q == S_READ);
  assign done_o         = (state_q == S_DONE);
  assign CPU_A_o        = 11'(idx_q);
  assign DCON_out_o     = dcon_q;
  assign src_addr_o     = src_addr_q;
  assign overrun_o      = overrun_q;
  assign mismatch_cnt_o = mis_q;

endmodule

// File: tb/tb_starforc_spr_dma.sv
// tb/tb_starforc_spr_dma.sv - self-checking bench for starforc_spr_dma
module tb_starforc_spr_dma;
  localparam int NB = 128;
`ifdef SPR_DMA_READBACK_EN
  localparam int PER_BYTE = 2 + 2 * 4 + 1;
`else
  localparam int PER_BYTE = 2 + 4 + 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, auto_vbl = 1'b0, nvblank = 1'b1;
  logic gnt_allow = 1'b1, corrupt = 1'b0;
  logic bus_req, bus_gnt, ncs, nmewr, nmerd, busy, done, overrun;
  logic [10:0] src_addr, cpu_a;
  logic [7:0] src_data, dcon_out, dcon_in, mism;

  logic [7:0] src_mem [NB];
  logic [7:0] spr_mem [NB];
  int wr_cnt [NB];
  int wr_total, done_cnt, first_cs, done_cyc, cyc = 0;
  int order_q [$];
  bit req_seen, rd_seen, prev_low;
  logic [10:0] held_a;
  logic [7:0] held_d;
  int checks = 0, errors = 0;

  assign bus_gnt = bus_req & gnt_allow;
  assign dcon_in = (corrupt && cpu_a[6:0] == 7'd5) ? 8'h00 : spr_mem[cpu_a[6:0]];

  starforc_spr_dma dut (
    .clk48m_i(clk), .reset_i(reset), .start_i(start), .auto_vbl_i(auto_vbl),
    .nVBLANK_i(nvblank), .bus_req_o(bus_req), .bus_gnt_i(bus_gnt),
    .src_addr_o(src_addr), .src_data_i(src_data), .CPU_A_o(cpu_a),
    .DCON_out_o(dcon_out), .DCON_in_i(dcon_in), .nCS_SPR_o(ncs),
    .nMEWR_o(nmewr), .nMERD_o(nmerd), .busy_o(busy), .done_o(done),
    .overrun_o(overrun), .mismatch_cnt_o(mism)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // work RAM: data valid one cycle after the address
  always @(posedge clk) src_data <= src_mem[src_addr[6:0]];
  always @(posedge clk) cyc <= cyc + 1;

  // sprite RAM model and bus observer
  always @(negedge clk) begin
    if (reset) begin
      foreach (wr_cnt[i]) begin wr_cnt[i] = 0; spr_mem[i] = 8'h00; end
      wr_total = 0; done_cnt = 0; first_cs = -1; done_cyc = 0;
      order_q.delete(); req_seen = 0; rd_seen = 0; prev_low = 0;
    end else begin
      if (!ncs && first_cs < 0) first_cs = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (bus_req) req_seen = 1;
      if (!nmerd) rd_seen = 1;
      if (!nmewr) begin
        if (prev_low) begin
          check("hold_addr", cpu_a, held_a);
          check("hold_data", dcon_out, held_d);
        end else begin
          check("wr_cs", ncs, 1'b0);
          spr_mem[cpu_a[6:0]] = dcon_out;
          wr_cnt[cpu_a[6:0]]++;
          wr_total++;
          order_q.push_back(int'(cpu_a));
          held_a = cpu_a;
          held_d = dcon_out;
        end
      end
      prev_low = !nmewr;
    end
  end

  task automatic do_reset();
    reset = 1; start = 0; gnt_allow = 1; corrupt = 0; auto_vbl = 0;
    repeat (3) @(negedge clk);
    reset = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_xfer(input string tag);
    int n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    check({tag, "_busy_up"}, busy, 1'b1);
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_busy_down"}, busy, 1'b0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_byte(input string tag, input int idx, input bit strobe);
    int n = 0;
    while (!(cpu_a == 11'(idx) && (strobe ? !nmewr : !ncs)) && n < 2000) begin
      @(negedge clk); n++;
    end
    check({tag, "_reach"}, {cpu_a, strobe ? nmewr : ncs}, {11'(idx), 1'b0});
  endtask

  task automatic check_table(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) check({tag, "_byte"}, {i[7:0], spr_mem[i]}, {i[7:0], src_mem[i]});
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) src_mem[i] = 8'($urandom);
  endtask

  initial begin
    int bad, upper;
    for (int i = 0; i < NB; i++) src_mem[i] = 8'(i) ^ 8'h5A;
    do_reset();
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_ncs", ncs, 1'b1);
    check("rst_nmewr", nmewr, 1'b1);
    check("rst_nmerd", nmerd, 1'b1);
    check("rst_cpu_a", cpu_a, 11'd0);
    check("rst_dcon", dcon_out, 8'd0);
    check("rst_src_addr", src_addr, 11'h000);
    check("rst_status", {busy, done, overrun}, 3'b000);
    check("rst_mism", mism, 8'd0);

    // full transfer with the i^5A pattern
    nvblank = 0;
    pulse_start();
    wait_xfer("full");
    check("full_done_cnt", done_cnt, 1);
    check("full_cycles", done_cyc - first_cs, NB * PER_BYTE);
    check("full_writes", wr_total, NB);
    bad = 0;
    for (int i = 0; i < order_q.size(); i++) if (order_q[i] != i) bad++;
    check("full_order", bad, 0);
    check_table("full", 0, NB - 1);
    check("full_overrun", overrun, 1'b0);
    check("full_mism", mism, 8'd0);
`ifdef SPR_DMA_READBACK_EN
    check("full_rd_seen", rd_seen, 1'b1);
`else
    check("full_rd_seen", rd_seen, 1'b0);
`endif

    // reset during STROBE of byte 17
    do_reset();
    nvblank = 0;
    pulse_start();
    wait_byte("rst17", 17, 1'b1);
    reset = 1;
    @(negedge clk);
    check("rst17_strobes", {ncs, nmewr, nmerd}, 3'b111);
    check("rst17_req_busy", {bus_req, busy}, 2'b00);
    check("rst17_cpu_a", cpu_a, 11'd0);

    // start outside vblank waits for the falling edge
    do_reset();
    fill_random();
    nvblank = 1;
    pulse_start();
    repeat (20) @(negedge clk);
    check("wait_vbl_req", req_seen, 1'b0);
    nvblank = 0;
    wait_xfer("wait_vbl");
    check("wait_vbl_done", done_cnt, 1);
    check_table("wait_vbl", 0, NB - 1);

    // vblank ends during SETUP of byte 40
    do_reset();
    fill_random();
    nvblank = 0;
    pulse_start();
    wait_byte("vend", 40, 1'b0);
    nvblank = 1;
    wait_xfer("vend");
    check("vend_byte40", wr_cnt[40], 1);
    upper = 0;
    for (int i = 41; i < NB; i++) upper += wr_cnt[i];
    check("vend_skipped", upper, 0);
    check("vend_writes", wr_total, 41);
    check("vend_overrun", overrun, 1'b1);
    check("vend_no_done", done_cnt, 0);
    check_table("vend", 0, 40);
    pulse_start();
    check("vend_clear", overrun, 1'b0);

    // grant lost for 10 cycles during STROBE of byte 10
    do_reset();
    fill_random();
    nvblank = 0;
    pulse_start();
    wait_byte("gnt", 10, 1'b1);
    gnt_allow = 0;
    @(negedge clk);
    check("gnt_strobes", {ncs, nmewr, nmerd}, 3'b111);
    check("gnt_req_held", bus_req, 1'b1);
    repeat (9) @(negedge clk);
    gnt_allow = 1;
    wait_xfer("gnt");
    check("gnt_byte10", wr_cnt[10], 2);
    check("gnt_writes", wr_total, NB + 1);
    check("gnt_done", done_cnt, 1);
    check_table("gnt", 0, NB - 1);

    // auto arming on the nVBLANK falling edge
    do_reset();
    fill_random();
    nvblank = 1;
    auto_vbl = 1;
    repeat (3) @(negedge clk);
    nvblank = 0;
    wait_xfer("auto");
    check("auto_done", done_cnt, 1);
    check_table("auto", 0, NB - 1);

`ifdef SPR_DMA_READBACK_EN
    // readback with address 5 returning zero
    do_reset();
    for (int i = 0; i < NB; i++) src_mem[i] = 8'(i) ^ 8'h5A;
    corrupt = 1;
    nvblank = 0;
    pulse_start();
    wait_xfer("rdbk");
    check("rdbk_mism", mism, 8'd1);
    check("rdbk_writes", wr_total, NB);
    check("rdbk_done", done_cnt, 1);
    check_table("rdbk", 0, NB - 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
